// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types and constants for the Keccak-f[100] datapath.
//   k_lane         one lane, LANE_W bits
//   k_state        full state, indexed [y][x] (plane, sheet)
//   k_lane_idx     linear lane index x + 5*y
//   k_sqz_state_e  squeeze FSM states
package keccak_pkg;
    localparam int LANE_W    = 4;
    localparam int NUM_PLANE = 5;
    localparam int NUM_SHEET = 5;
    localparam int NUM_LANES = NUM_PLANE * NUM_SHEET;

    typedef logic [LANE_W-1:0] k_lane;
    typedef k_lane [NUM_PLANE-1:0][NUM_SHEET-1:0] k_state;
    typedef logic [4:0] k_lane_idx;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } k_sqz_state_e;
endpackage

// File: rtl/keccak_lane_sel.sv
// keccak_lane_sel: combinational 25:1 lane multiplexer, shared by the absorb
// and squeeze paths.
//   st_i    full state, indexed [y][x]
//   idx_i   linear lane index x + 5*y
//   lane_o  selected lane; zero for indices 25..31
import keccak_pkg::*;

module keccak_lane_sel (
    input  k_state    st_i,
    input  k_lane_idx idx_i,
    output k_lane     lane_o
);
    // Compare against every legal index rather than dividing by 5; the
    // comparison form maps to a flat mux with no divider.
    always_comb begin
        lane_o = '0;
        for (int y = 0; y < NUM_PLANE; y++) begin
            for (int x = 0; x < NUM_SHEET; x++) begin
                if (idx_i == k_lane_idx'(y * NUM_SHEET + x)) begin
                    lane_o = st_i[y][x];
                end
            end
        end
    end
endmodule

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: captures one permuted Keccak-f[100] state and streams its
// first len rate lanes, x-fastest within each plane, on a lane-wide stream.
//   clk, rst          clock, synchronous active-high reset
//   st_valid_i/st_ready_o  state input handshake (ready only in IDLE)
//   st_i, len_i       state and lane count, sampled on acceptance
//   lane_valid_o/lane_ready_i  lane output handshake
//   lane_o, lane_idx_o, lane_last_o  lane data, linear index, final-lane flag
//   dbg_state_o       current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never depends on ready, and payload holds stable while
// valid=1 and ready=0. st_ready_o is a pure function of the FSM state, so
// there is always one IDLE cycle between consecutive blocks.
import keccak_pkg::*;

module keccak_squeeze #(
    parameter int RATE_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid_i,
    output logic         st_ready_o,
    input  k_state       st_i,
    input  logic [4:0]   len_i,
    output logic         lane_valid_o,
    input  logic         lane_ready_i,
    output k_lane        lane_o,
    output k_lane_idx    lane_idx_o,
    output logic         lane_last_o,
    output k_sqz_state_e dbg_state_o
);
    localparam k_lane_idx RATE_LEN = k_lane_idx'(RATE_LANES);

    k_sqz_state_e r_state;
    k_state       r_state_q;
    k_lane_idx    r_len_q;
    k_lane_idx    r_cnt;

    k_lane_idx    w_len_eff;
    k_lane        w_lane;
    logic         w_last;
    logic         w_emit;

    // Zero or oversize requests fall back to the full rate.
    assign w_len_eff = ((len_i == 5'd0) || (len_i > RATE_LEN)) ? RATE_LEN : len_i;
    assign w_last    = (r_cnt == (r_len_q - 5'd1));
    assign w_emit    = (r_state == EMIT);

    keccak_lane_sel u_lane_sel (
        .st_i   (r_state_q),
        .idx_i  (r_cnt),
        .lane_o (w_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_state_q <= '0;
            r_len_q   <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (st_valid_i) begin
                        r_state_q <= st_i;
                        r_len_q   <= w_len_eff;
                        r_cnt     <= '0;
                        r_state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (lane_ready_i) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // All outputs decode directly from registers; payload is forced to zero
    // outside EMIT.
    assign st_ready_o   = !w_emit;
    assign lane_valid_o = w_emit;
    assign lane_o       = w_emit ? w_lane : '0;
    assign lane_idx_o   = w_emit ? r_cnt : '0;
    assign lane_last_o  = w_emit && w_last;
    assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_keccak_squeeze.sv
import keccak_pkg::*;

module tb_keccak_squeeze;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- DUT A: RATE_LANES = 4 ----------------
    logic         a_st_valid = 1'b0;
    logic         a_st_ready;
    k_state       a_st = '0;
    logic [4:0]   a_len = 5'd0;
    logic         a_lane_valid;
    logic         a_ready = 1'b1;
    k_lane        a_lane;
    k_lane_idx    a_idx;
    logic         a_last;
    k_sqz_state_e a_dbg;

    keccak_squeeze #(.RATE_LANES(4)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .st_valid_i   (a_st_valid),
        .st_ready_o   (a_st_ready),
        .st_i         (a_st),
        .len_i        (a_len),
        .lane_valid_o (a_lane_valid),
        .lane_ready_i (a_ready),
        .lane_o       (a_lane),
        .lane_idx_o   (a_idx),
        .lane_last_o  (a_last),
        .dbg_state_o  (a_dbg)
    );

    // ---------------- DUT B: RATE_LANES = 25 ----------------
    logic         b_st_valid = 1'b0;
    logic         b_st_ready;
    k_state       b_st = '0;
    logic [4:0]   b_len = 5'd0;
    logic         b_lane_valid;
    logic         b_ready = 1'b1;
    k_lane        b_lane;
    k_lane_idx    b_idx;
    logic         b_last;
    k_sqz_state_e b_dbg;

    keccak_squeeze #(.RATE_LANES(25)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .st_valid_i   (b_st_valid),
        .st_ready_o   (b_st_ready),
        .st_i         (b_st),
        .len_i        (b_len),
        .lane_valid_o (b_lane_valid),
        .lane_ready_i (b_ready),
        .lane_o       (b_lane),
        .lane_idx_o   (b_idx),
        .lane_last_o  (b_last),
        .dbg_state_o  (b_dbg)
    );

    // Expected entries are {last, idx[4:0], lane[3:0]}.
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- lane_ready driver for A ----------------
    // mode 0: always ready; mode 1: pattern 1,0,0 repeating.
    int ready_mode  = 0;
    int ready_phase = 0;
    always @(posedge clk) begin
        #1;
        a_ready = (ready_mode == 0) ? 1'b1 : (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
    end

    // ---------------- scoreboard monitors ----------------
    logic       a_stall_prev = 1'b0;
    logic [9:0] a_held = '0;

    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] e;
        act = {a_last, a_idx, a_lane};
        if (!rst) begin
            if (a_stall_prev && a_lane_valid)
                chk("stall_hold_a", int'(act), int'(a_held));
            if (a_lane_valid && a_ready) begin
                if (exp_a.size() == 0) begin
                    chk("unexpected_lane_a", int'(act), -1);
                end else begin
                    e = exp_a.pop_front();
                    chk("lane_a", int'(act), int'(e));
                end
            end
            a_stall_prev = a_lane_valid && !a_ready;
            a_held       = act;
        end else begin
            a_stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && b_lane_valid && b_ready) begin
            if (exp_b.size() == 0) begin
                chk("unexpected_lane_b", int'({b_last, b_idx, b_lane}), -1);
            end else begin
                e = exp_b.pop_front();
                chk("lane_b", int'({b_last, b_idx, b_lane}), int'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp_a(input k_state st, input int n);
        for (int i = 0; i < n; i++)
            exp_a.push_back({(i == n - 1), 5'(i), st[i / 5][i % 5]});
    endtask

    // Returns #1 after the accepting edge.
    task automatic drive_a(input k_state st, input logic [4:0] len);
        bit ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(posedge clk); #1;
            if (a_st_ready) ok = 1;
        end
        if (!ok) chk("st_ready_timeout_a", 0, 1);
        a_st = st; a_len = len; a_st_valid = 1'b1;
        @(posedge clk); #1;
        a_st_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        bit ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            if (a_st_ready && exp_a.size() == 0) ok = 1;
        end
        if (!ok) chk("drain_timeout_a", exp_a.size(), 0);
    endtask

    function automatic k_state make_state(input int mul, input int add, input int base);
        k_state s;
        s = '0;
        for (int i = 0; i < 25; i++)
            s[i / 5][i % 5] = 4'((base + mul * i + add) % 16);
        return s;
    endfunction

    // ---------------- directed sequence ----------------
    k_state st1, st2, st6;

    initial begin
        st1 = make_state(1, 0, 0);    // lane i = i mod 16
        st2 = make_state(3, 5, 0);    // lane i = (3i+5) mod 16
        st6 = make_state(-1, 0, 24 + 16 * 4); // lane i = (24-i) mod 16

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_st_ready", a_st_ready, 1);
        chk("rst_lane_valid", a_lane_valid, 0);
        chk("rst_lane", a_lane, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_last", a_last, 0);
        rst = 1'b0;

        // 1: len 4, full throughput, latency and bubble
        push_exp_a(st1, 4);
        drive_a(st1, 5'd4);
        chk("t1_valid_c1", a_lane_valid, 1);
        chk("t1_idx_c1", a_idx, 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk("t1_valid", a_lane_valid, 1);
            chk("t1_idx", a_idx, k);
        end
        @(posedge clk); #1;
        chk("t1_ready_after", a_st_ready, 1);
        chk("t1_valid_after", a_lane_valid, 0);
        wait_idle_a();

        // 2: backpressure pattern 1,0,0
        ready_mode = 1;
        push_exp_a(st1, 4);
        drive_a(st1, 5'd4);
        wait_idle_a();
        ready_mode = 0;

        // 3: length clamp and single lane
        push_exp_a(st2, 4);
        drive_a(st2, 5'd0);
        wait_idle_a();
        push_exp_a(st1, 4);
        drive_a(st1, 5'd20);
        wait_idle_a();
        push_exp_a(st2, 1);
        drive_a(st2, 5'd1);
        chk("t3_single_last", a_last, 1);
        @(posedge clk); #1;
        chk("t3_single_done", a_st_ready, 1);
        wait_idle_a();

        // 4: st_valid held across two different states
        push_exp_a(st1, 4);
        push_exp_a(st2, 4);
        drive_a(st1, 5'd4);
        a_st = st2;
        a_st_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_still_emit", a_lane_valid, 1);
        @(posedge clk); #1;
        chk("t4_bubble_ready", a_st_ready, 1);
        chk("t4_bubble_valid", a_lane_valid, 0);
        @(posedge clk); #1;
        a_st_valid = 1'b0;
        chk("t4_second_valid", a_lane_valid, 1);
        chk("t4_second_idx", a_idx, 0);
        wait_idle_a();

        // 5: reset after two lanes
        push_exp_a(st1, 4);
        drive_a(st1, 5'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_idx_before_rst", a_idx, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_valid", a_lane_valid, 0);
        chk("t5_ready", a_st_ready, 1);
        chk("t5_lane", a_lane, 0);
        chk("t5_idx", a_idx, 0);
        chk("t5_remaining", exp_a.size(), 2);
        exp_a.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_more_lanes", a_lane_valid, 0);
        push_exp_a(st2, 4);
        drive_a(st2, 5'd4);
        chk("t5_restart_idx", a_idx, 0);
        wait_idle_a();

        // 6: RATE_LANES=25, full length on instance B
        chk("t6_lane0_hand", st6[0][0], 8);
        chk("t6_lane24_hand", st6[4][4], 0);
        for (int i = 0; i < 25; i++)
            exp_b.push_back({(i == 24), 5'(i), st6[i / 5][i % 5]});
        @(posedge clk); #1;
        b_st = st6; b_len = 5'd25; b_st_valid = 1'b1;
        @(posedge clk); #1;
        b_st_valid = 1'b0;
        begin
            bit ok = 0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge clk); #1;
                if (b_st_ready && exp_b.size() == 0) ok = 1;
            end
            if (!ok) chk("drain_timeout_b", exp_b.size(), 0);
        end

        chk("exp_a_empty", exp_a.size(), 0);
        chk("exp_b_empty", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests_failed %0d", tests_failed);
        $fatal(1, "watchdog");
    end
endmodule
